framebuffer_write_coalescer: RTL and testbench
==============================================

FRAMEBUFFER_WRITE_COALESCER -- requirements
Module: framebuffer_write_coalescer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, pixel index width.
REQ-002 SHALL have parameter PIXEL_WIDTH, default 16, bits per pixel, multiple of 8; MASK_WIDTH = PIXEL_WIDTH/8 (derived).
REQ-003 SHALL have parameter STRB_WIDTH, default 16, bytes per memory beat; PIX_PER_BEAT = STRB_WIDTH/MASK_WIDTH, power of two (derived); BEAT_ADDR_WIDTH = ADDR_WIDTH - log2(PIX_PER_BEAT) (derived).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 8, idle cycles before forced flush (used only with REQ-030).
REQ-005 SHALL have ports: aclk  in  1  clock (all logic on rising edge).
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 s_valid / s_ready  in / out  1 / 1  pixel input handshake.
REQ-008 s_addr  in  ADDR_WIDTH  pixel index; low log2(PIX_PER_BEAT) bits = slot, upper bits = beat address.
REQ-009 s_data  in  PIXEL_WIDTH  pixel value; s_mask  in  MASK_WIDTH  per-byte write enable; s_last  in  1  close beat after this pixel.
REQ-010 m_valid / m_ready  out / in  1 / 1  beat output handshake.
REQ-011 m_addr  out  BEAT_ADDR_WIDTH; m_data  out  STRB_WIDTH*8; m_strb  out  STRB_WIDTH  byte strobes.
REQ-012 idle  out  1  high when accumulator empty and m_valid low.

Function
REQ-013 SHALL hold one accumulator (acc_valid, acc_close, acc_addr, acc_data, acc_strb) and one output register driving m_*.
REQ-014 out_free = !m_valid || m_ready; hit = acc_valid && !acc_close && s_addr beat == acc_addr.
REQ-015 xfer = acc_valid && out_free && (acc_close || (s_valid && !hit) || timeout_fire); on xfer output register loads acc_addr/acc_data/acc_strb and m_valid <= 1.
REQ-016 s_ready = !acc_valid || hit || xfer (combinational); otherwise stall, no pixel lost or duplicated.
REQ-017 Accept with hit: merge; bytes with s_mask set at slot replace acc_data bytes, acc_strb bits OR in; later pixel wins.
REQ-018 Accept without hit: accumulator loaded fresh (strb = mask at slot, other bytes zero-strobed), acc_valid <= 1.
REQ-019 acc_close <= s_last || resulting acc_strb all ones, on every accept.
REQ-020 Slot placement: strobe = mask << (slot*MASK_WIDTH), data = s_data << (slot*PIXEL_WIDTH).
REQ-021 xfer without accept clears acc_valid; xfer with accept reloads accumulator same cycle.
REQ-022 m_valid clears on m_ready without new xfer; m_* stable while m_valid && !m_ready.
REQ-023 Latency: closing pixel accepted cycle N with out_free -> m_valid high cycle N+2.
REQ-024 s_mask all zero: pixel accepted, strobes unchanged, still participates in hit/close logic.

Reset
REQ-025 reset SHALL asynchronously clear acc_valid, acc_close, acc_strb, m_valid, m_addr, m_data, m_strb, timeout counter.
REQ-026 After reset: s_ready = 1, idle = 1, m_valid = 0; reset mid-beat discards accumulated and pending data.

Configuration
REQ-027 Macro FRAMEBUFFER_WRITE_COALESCER_TIMEOUT_EN SHALL enable idle flush.
REQ-028 Defined: counter increments each cycle acc_valid && no accept, clears on accept or xfer; timeout_fire when counter == TIMEOUT_CYCLES.
REQ-029 Undefined: no counter, timeout_fire = 0, TIMEOUT_CYCLES ignored; accumulator held until close or miss.
REQ-030 TIMEOUT_CYCLES SHALL be >= 1; counter width $clog2(TIMEOUT_CYCLES+1).

Verification (defaults, PIX_PER_BEAT = 8)
REQ-031 Pixels addr 0..7, mask 2'b11, m_ready=1 -> one beat m_addr 0, m_strb 16'hFFFF, all data correct.
REQ-032 addr 3, data 16'hABCD, mask 2'b11, s_last -> m_addr 0, m_strb 16'h00C0, m_data[63:48]=16'hABCD, m_valid 2 cycles after accept.
REQ-033 addr 5 then addr 13 -> beat m_addr 0, m_strb 16'h0C00 emitted on addr 13 accept; addr 13 held in accumulator (idle=0).
REQ-034 addr 2 data 16'h1122 mask 2'b01, then addr 2 data 16'h3344 mask 2'b10, s_last -> m_strb 16'h0030, m_data[47:32]=16'h3322.
REQ-035 m_ready=0, pixels to beats 0, 1, 2 -> s_ready low on beat-2 pixel until m_ready=1; beats 0,1 emitted in order.
REQ-036 Macro defined, TIMEOUT_CYCLES=4, single pixel addr 9 -> m_addr 1, m_strb 16'h000C, m_valid after 4 idle cycles; undefined -> never flushes.

Source files
------------

// File: rtl/framebuffer_write_coalescer_if.sv
// ----------------------------------------------------------------------------
// framebuffer_write_coalescer_if
//
// Bundles the pixel-in and beat-out handshakes of the framebuffer write
// coalescer.
//
//   pixel side : s_valid, s_ready, s_addr, s_data, s_mask, s_last
//   beat side  : m_valid, m_ready, m_addr, m_data, m_strb
//   status     : idle
//
// Modports
//   master : pixel producer / beat consumer (drives s_* and m_ready)
//   slave  : the coalescer itself (drives s_ready, m_* and idle)
// ----------------------------------------------------------------------------
interface framebuffer_write_coalescer_if #(
  parameter int ADDR_WIDTH  = 16,
  parameter int PIXEL_WIDTH = 16,
  parameter int STRB_WIDTH  = 16
);

  localparam int MASK_WIDTH      = PIXEL_WIDTH / 8;
  localparam int PIX_PER_BEAT    = STRB_WIDTH / MASK_WIDTH;
  localparam int BEAT_ADDR_WIDTH = ADDR_WIDTH - $clog2(PIX_PER_BEAT);

  // pixel input
  logic                       s_valid;
  logic                       s_ready;
  logic [ADDR_WIDTH-1:0]      s_addr;
  logic [PIXEL_WIDTH-1:0]     s_data;
  logic [MASK_WIDTH-1:0]      s_mask;
  logic                       s_last;

  // beat output
  logic                       m_valid;
  logic                       m_ready;
  logic [BEAT_ADDR_WIDTH-1:0] m_addr;
  logic [STRB_WIDTH*8-1:0]    m_data;
  logic [STRB_WIDTH-1:0]      m_strb;

  // status
  logic                       idle;

  modport master (
    output s_valid, s_addr, s_data, s_mask, s_last, m_ready,
    input  s_ready, m_valid, m_addr, m_data, m_strb, idle
  );

  modport slave (
    input  s_valid, s_addr, s_data, s_mask, s_last, m_ready,
    output s_ready, m_valid, m_addr, m_data, m_strb, idle
  );

endinterface

// File: rtl/framebuffer_write_coalescer.sv
// ----------------------------------------------------------------------------
// framebuffer_write_coalescer
//
// Collects individual pixel writes into full-width memory beats. Pixels that
// fall into the same beat are merged byte-by-byte into a single accumulator;
// the accumulator is handed to a registered output stage when it is closed
// (s_last or every byte strobed), when a pixel for a different beat arrives,
// or -- optionally -- after the accumulator has sat idle for too long.
//
// Ports
//   aclk    in   rising-edge clock
//   reset   in   asynchronous, active-high reset
//   bus     slave modport of framebuffer_write_coalescer_if
//             s_valid/s_ready/s_addr/s_data/s_mask/s_last : pixel input
//             m_valid/m_ready/m_addr/m_data/m_strb        : beat output
//             idle : accumulator empty and no beat pending
//
// Configuration
//   FRAMEBUFFER_WRITE_COALESCER_TIMEOUT_EN
//     When defined, an idle counter flushes a partially filled accumulator
//     after TIMEOUT_CYCLES cycles without a new pixel. When undefined the
//     accumulator is held until it closes or a different beat arrives, and
//     TIMEOUT_CYCLES has no effect (still range-checked).
// ----------------------------------------------------------------------------
module framebuffer_write_coalescer #(
  parameter int ADDR_WIDTH     = 16,
  parameter int PIXEL_WIDTH    = 16,
  parameter int STRB_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 8
) (
  input  logic                         aclk,
  input  logic                         reset,
  framebuffer_write_coalescer_if.slave bus
);

  localparam int MASK_WIDTH      = PIXEL_WIDTH / 8;
  localparam int PIX_PER_BEAT    = STRB_WIDTH / MASK_WIDTH;
  localparam int SLOT_WIDTH      = $clog2(PIX_PER_BEAT);
  localparam int BEAT_ADDR_WIDTH = ADDR_WIDTH - SLOT_WIDTH;
  localparam int DATA_WIDTH      = STRB_WIDTH * 8;

  // Parameter sanity checks; a bad configuration stops elaboration.
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("framebuffer_write_coalescer: TIMEOUT_CYCLES must be >= 1");
  end
  if (PIX_PER_BEAT < 2 || (PIX_PER_BEAT & (PIX_PER_BEAT - 1)) != 0) begin : g_bad_geometry
    $error("framebuffer_write_coalescer: pixels per beat must be a power of two >= 2");
  end
  if ((PIXEL_WIDTH % 8) != 0) begin : g_bad_pixel
    $error("framebuffer_write_coalescer: PIXEL_WIDTH must be a multiple of 8");
  end

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic                       acc_valid_r;
  logic                       acc_close_r;
  logic [BEAT_ADDR_WIDTH-1:0] acc_addr_r;
  logic [DATA_WIDTH-1:0]      acc_data_r;
  logic [STRB_WIDTH-1:0]      acc_strb_r;

  logic                       m_valid_r;
  logic [BEAT_ADDR_WIDTH-1:0] m_addr_r;
  logic [DATA_WIDTH-1:0]      m_data_r;
  logic [STRB_WIDTH-1:0]      m_strb_r;

  // --------------------------------------------------------------------------
  // Combinational control
  // --------------------------------------------------------------------------
  logic [BEAT_ADDR_WIDTH-1:0] s_beat_s;
  logic [SLOT_WIDTH-1:0]      s_slot_s;
  logic [31:0]                strb_shamt_s;
  logic [31:0]                data_shamt_s;
  logic [STRB_WIDTH-1:0]      strb_shift_s;
  logic [DATA_WIDTH-1:0]      data_shift_s;
  logic                       out_free_s;
  logic                       hit_s;
  logic                       timeout_fire_s;
  logic                       xfer_s;
  logic                       s_ready_s;
  logic                       accept_s;

  assign s_beat_s     = bus.s_addr[ADDR_WIDTH-1:SLOT_WIDTH];
  assign s_slot_s     = bus.s_addr[SLOT_WIDTH-1:0];
  assign strb_shamt_s = 32'(s_slot_s) * 32'(MASK_WIDTH);
  assign data_shamt_s = 32'(s_slot_s) * 32'(PIXEL_WIDTH);
  assign strb_shift_s = {{(STRB_WIDTH-MASK_WIDTH){1'b0}}, bus.s_mask} << strb_shamt_s;
  assign data_shift_s = {{(DATA_WIDTH-PIXEL_WIDTH){1'b0}}, bus.s_data} << data_shamt_s;

  assign out_free_s = !m_valid_r || bus.m_ready;
  // A closed accumulator never merges: the next pixel, even to the same beat,
  // starts a new beat once the closed one has moved to the output stage.
  assign hit_s      = acc_valid_r && !acc_close_r && (s_beat_s == acc_addr_r);
  assign xfer_s     = acc_valid_r && out_free_s &&
                      (acc_close_r || (bus.s_valid && !hit_s) || timeout_fire_s);
  assign s_ready_s  = !acc_valid_r || hit_s || xfer_s;
  assign accept_s   = bus.s_valid && s_ready_s;

  // Next accumulator contents for an accepted pixel.
  logic [DATA_WIDTH-1:0] base_data_s;
  logic [STRB_WIDTH-1:0] base_strb_s;
  logic [DATA_WIDTH-1:0] next_data_s;
  logic [STRB_WIDTH-1:0] next_strb_s;
  logic                  next_close_s;

  // Merge the slot-shifted pixel into the accumulator (or into an empty one).
  always_comb begin
    base_data_s  = acc_data_r;
    base_strb_s  = acc_strb_r;
    next_data_s  = '0;
    next_strb_s  = '0;
    next_close_s = 1'b0;
    // A fresh load (empty accumulator, or the old beat leaving this cycle)
    // starts from nothing so no stale bytes or strobes carry over.
    if (xfer_s || !acc_valid_r) begin
      base_data_s = '0;
      base_strb_s = '0;
    end else begin
      base_data_s = acc_data_r;
      base_strb_s = acc_strb_r;
    end
    for (int i = 0; i < STRB_WIDTH; i++) begin
      if (strb_shift_s[i]) begin
        next_data_s[i*8 +: 8] = data_shift_s[i*8 +: 8];
      end else begin
        next_data_s[i*8 +: 8] = base_data_s[i*8 +: 8];
      end
    end
    next_strb_s  = base_strb_s | strb_shift_s;
    next_close_s = bus.s_last || (&next_strb_s);
  end

  // --------------------------------------------------------------------------
  // Optional idle flush
  // --------------------------------------------------------------------------
`ifdef FRAMEBUFFER_WRITE_COALESCER_TIMEOUT_EN
  localparam int TMO_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_WIDTH-1:0] TMO_LIMIT = TMO_WIDTH'(TIMEOUT_CYCLES);

  logic [TMO_WIDTH-1:0] tmo_cnt_r;

  // Count cycles the accumulator waits without a new pixel; saturate at the
  // limit so a blocked output stage does not wrap the counter.
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      tmo_cnt_r <= '0;
    end else if (accept_s || xfer_s || !acc_valid_r) begin
      tmo_cnt_r <= '0;
    end else if (tmo_cnt_r != TMO_LIMIT) begin
      tmo_cnt_r <= tmo_cnt_r + TMO_WIDTH'(1);
    end
  end

  assign timeout_fire_s = acc_valid_r && (tmo_cnt_r == TMO_LIMIT);
`else
  assign timeout_fire_s = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Sequential logic
  // --------------------------------------------------------------------------

  // Accumulator: load/merge on accept, empty on a transfer with no new pixel.
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      acc_valid_r <= 1'b0;
      acc_close_r <= 1'b0;
      acc_addr_r  <= '0;
      acc_data_r  <= '0;
      acc_strb_r  <= '0;
    end else if (accept_s) begin
      acc_valid_r <= 1'b1;
      acc_close_r <= next_close_s;
      acc_addr_r  <= s_beat_s;
      acc_data_r  <= next_data_s;
      acc_strb_r  <= next_strb_s;
    end else if (xfer_s) begin
      acc_valid_r <= 1'b0;
      acc_close_r <= 1'b0;
    end
  end

  // Output stage: capture the accumulator on transfer, drop after handshake.
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      m_valid_r <= 1'b0;
      m_addr_r  <= '0;
      m_data_r  <= '0;
      m_strb_r  <= '0;
    end else if (xfer_s) begin
      m_valid_r <= 1'b1;
      m_addr_r  <= acc_addr_r;
      m_data_r  <= acc_data_r;
      m_strb_r  <= acc_strb_r;
    end else if (bus.m_ready) begin
      m_valid_r <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.s_ready = s_ready_s;
  assign bus.m_valid = m_valid_r;
  assign bus.m_addr  = m_addr_r;
  assign bus.m_data  = m_data_r;
  assign bus.m_strb  = m_strb_r;
  assign bus.idle    = !acc_valid_r && !m_valid_r;

endmodule

// File: tb/tb_framebuffer_write_coalescer.sv
// ----------------------------------------------------------------------------
// tb_framebuffer_write_coalescer
//
// Directed bench for framebuffer_write_coalescer at default geometry
// (16-bit pixels, 16-byte beats, 8 pixels per beat) with TIMEOUT_CYCLES = 4.
// Beats leaving the DUT are captured by a monitor and compared in order
// against hand-computed expectations.
// ----------------------------------------------------------------------------
module tb_framebuffer_write_coalescer;

  logic aclk = 1'b0;
  logic reset;

  always #5 aclk = ~aclk;

  framebuffer_write_coalescer_if #(
    .ADDR_WIDTH (16),
    .PIXEL_WIDTH(16),
    .STRB_WIDTH (16)
  ) bus ();

  framebuffer_write_coalescer #(
    .ADDR_WIDTH    (16),
    .PIXEL_WIDTH   (16),
    .STRB_WIDTH    (16),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .aclk (aclk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct packed {
    logic [12:0]  addr;
    logic [127:0] data;
    logic [15:0]  strb;
  } beat_t;

  beat_t beat_q[$];
  int    n_cmp   = 0;
  int    n_err   = 0;
  int    n_beats = 0;

  // Capture every beat that will be handed over on the next rising edge.
  always @(negedge aclk) begin
    if (!reset && bus.m_valid && bus.m_ready) begin
      beat_q.push_back('{addr: bus.m_addr, data: bus.m_data, strb: bus.m_strb});
      n_beats++;
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  // Present one pixel and hold it until accepted (bounded wait).
  task automatic send(input logic [15:0] a, input logic [15:0] d,
                      input logic [1:0] m, input logic l);
    bit got;
    got         = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_addr  = a;
    bus.s_data  = d;
    bus.s_mask  = m;
    bus.s_last  = l;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge aclk);
      if (bus.s_ready) got = 1'b1;
      @(posedge aclk);
      #1;
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    check("send_accepted", 128'(got), 128'(1'b1));
  endtask

  // Pop the oldest captured beat (bounded wait) and compare all fields.
  task automatic expect_beat(input string tag, input logic [12:0] a,
                             input logic [127:0] d, input logic [15:0] s);
    beat_t b;
    for (int i = 0; i < 20 && beat_q.size() == 0; i++) step(1);
    check({tag, "_present"}, 128'(beat_q.size() != 0), 128'(1'b1));
    if (beat_q.size() != 0) begin
      b = beat_q.pop_front();
      check({tag, "_addr"}, 128'(b.addr), 128'(a));
      check({tag, "_data"}, b.data, d);
      check({tag, "_strb"}, 128'(b.strb), 128'(s));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [127:0] exp_d;
    int           nb;

    reset       = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_addr  = 16'd0;
    bus.s_data  = 16'd0;
    bus.s_mask  = 2'b00;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b1;
    step(3);

    // Reset state
    check("rst_s_ready", 128'(bus.s_ready), 128'(1'b1));
    check("rst_idle",    128'(bus.idle),    128'(1'b1));
    check("rst_m_valid", 128'(bus.m_valid), 128'(1'b0));
    reset = 1'b0;
    step(1);

    // Single closing pixel: slot 3, two-cycle latency
    send(16'd3, 16'hABCD, 2'b11, 1'b1);
    @(negedge aclk);
    check("lat_n1_m_valid", 128'(bus.m_valid), 128'(1'b0));
    @(negedge aclk);
    check("lat_n2_m_valid", 128'(bus.m_valid), 128'(1'b1));
    step(1);
    exp_d = '0;
    exp_d[63:48] = 16'hABCD;
    expect_beat("single", 13'd0, exp_d, 16'h00C0);
    step(1);
    check("single_idle", 128'(bus.idle), 128'(1'b1));

    // Eight pixels fill beat 0 and close it by full strobes
    for (int i = 0; i < 8; i++) send(16'(i), 16'h1000 + 16'(i), 2'b11, 1'b0);
    exp_d = '0;
    for (int i = 0; i < 8; i++) exp_d[i*16 +: 16] = 16'h1000 + 16'(i);
    expect_beat("full", 13'd0, exp_d, 16'hFFFF);
    step(2);
    check("full_beat_count", 128'(n_beats), 128'(2));
    check("full_idle", 128'(bus.idle), 128'(1'b1));

    // Miss: addr 5 then addr 13 flushes beat 0, keeps addr 13
    send(16'd5,  16'h5555, 2'b11, 1'b0);
    send(16'd13, 16'hDDDD, 2'b11, 1'b0);
    @(negedge aclk);
    check("miss_m_valid", 128'(bus.m_valid), 128'(1'b1));
    check("miss_m_strb",  128'(bus.m_strb),  128'(16'h0C00));
    check("miss_idle",    128'(bus.idle),    128'(1'b0));
    step(1);
    exp_d = '0;
    exp_d[95:80] = 16'h5555;
    expect_beat("miss", 13'd0, exp_d, 16'h0C00);

    // Zero-mask pixel still hits and closes without touching data
    send(16'd13, 16'h0000, 2'b00, 1'b1);
    exp_d = '0;
    exp_d[95:80] = 16'hDDDD;
    expect_beat("zero_mask", 13'd1, exp_d, 16'h0C00);

    // Byte merge within one slot: later pixel supplies the high byte
    send(16'd2, 16'h1122, 2'b01, 1'b0);
    send(16'd2, 16'h3344, 2'b10, 1'b1);
    exp_d = '0;
    exp_d[47:32] = 16'h3322;
    expect_beat("merge", 13'd0, exp_d, 16'h0030);

    // Back-pressure: beats 0,1,2 with m_ready low
    step(2);
    bus.m_ready = 1'b0;
    send(16'd1, 16'h0101, 2'b11, 1'b0);
    send(16'd9, 16'h0909, 2'b11, 1'b0);
    bus.s_valid = 1'b1;
    bus.s_addr  = 16'd17;
    bus.s_data  = 16'h1717;
    bus.s_mask  = 2'b11;
    bus.s_last  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      check("stall_s_ready", 128'(bus.s_ready), 128'(1'b0));
      check("stall_m_valid", 128'(bus.m_valid), 128'(1'b1));
      check("stall_m_addr",  128'(bus.m_addr),  128'(13'd0));
      step(1);
    end
    bus.m_ready = 1'b1;
    @(negedge aclk);
    check("unstall_s_ready", 128'(bus.s_ready), 128'(1'b1));
    step(1);
    bus.s_valid = 1'b0;
    send(16'd17, 16'h0000, 2'b00, 1'b1);
    exp_d = '0;
    exp_d[31:16] = 16'h0101;
    expect_beat("order_b0", 13'd0, exp_d, 16'h000C);
    exp_d = '0;
    exp_d[31:16] = 16'h0909;
    expect_beat("order_b1", 13'd1, exp_d, 16'h000C);
    exp_d = '0;
    exp_d[31:16] = 16'h1717;
    expect_beat("order_b2", 13'd2, exp_d, 16'h000C);
    step(2);

    // Lone pixel at addr 9: flushed by timeout or held indefinitely
    nb = n_beats;
    send(16'd9, 16'h9999, 2'b11, 1'b0);
`ifdef FRAMEBUFFER_WRITE_COALESCER_TIMEOUT_EN
    for (int k = 0; k < 5; k++) begin
      @(negedge aclk);
      check("tmo_wait_m_valid", 128'(bus.m_valid), 128'(1'b0));
      step(1);
    end
    @(negedge aclk);
    check("tmo_fire_m_valid", 128'(bus.m_valid), 128'(1'b1));
    step(1);
`else
    step(20);
    check("hold_idle",     128'(bus.idle), 128'(1'b0));
    check("hold_no_beat",  128'(n_beats),  128'(nb));
    send(16'd9, 16'h0000, 2'b00, 1'b1);
`endif
    exp_d = '0;
    exp_d[31:16] = 16'h9999;
    expect_beat("lone", 13'd1, exp_d, 16'h000C);
    step(2);

    // Reset in the middle of a beat discards the partial accumulator
    send(16'd4, 16'h4444, 2'b11, 1'b0);
    reset = 1'b1;
    #1;
    check("mid_rst_idle",    128'(bus.idle),    128'(1'b1));
    check("mid_rst_s_ready", 128'(bus.s_ready), 128'(1'b1));
    check("mid_rst_m_valid", 128'(bus.m_valid), 128'(1'b0));
    step(1);
    reset = 1'b0;
    step(1);
    send(16'd0, 16'h0A0A, 2'b11, 1'b1);
    exp_d = '0;
    exp_d[15:0] = 16'h0A0A;
    expect_beat("post_rst", 13'd0, exp_d, 16'h0003);

    step(3);
    check("total_beats",   128'(n_beats),       128'(10));
    check("queue_drained", 128'(beat_q.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
